wbs_mem_responder: RTL and testbench
====================================

Name: wbs_mem_responder

Overview:
- Wishbone slave responder for the ANN accelerator user project.
- Decodes `wbs_adr_i` into control/status registers and four SRAM regions: query, leaf, best, node.
- Generates the single-cycle `wbs_ack_o`, splits 64-bit SRAM words into two 32-bit bus halves, and drives the active-low SRAM control ports.
- Sits between the Caravel Wishbone bus and the accelerator core/SRAM macros inside the user project top.

Parameters:
- MEM_ADDR_W, 12, SRAM word-index width (covers 3072 leaf words).
- MEM_DATA_W, 64, SRAM word width.
- NODE_DATA_W, 22, node word width (index[10:0], median[21:11]).

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- wbs_stb_i  in  1  strobe
- wbs_cyc_i  in  1  cycle valid
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte select (ignored; full-word access only)
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- mem_csb  out  4  active-low chip select, one-hot: [0] query, [1] leaf, [2] best, [3] node
- mem_web  out  1  active-low write enable
- mem_addr  out  MEM_ADDR_W  SRAM word index
- mem_wdata  out  MEM_DATA_W  SRAM write data
- query_rdata, leaf_rdata, best_rdata  in  MEM_DATA_W  SRAM read data, valid one cycle after csb low
- node_rdata  in  NODE_DATA_W  node SRAM read data
- mode  out  1  mode register bit
- debug  out  1  debug register bit
- fsm_start  out  1  one-cycle start pulse
- fsm_done  in  1  done pulse from core
- fsm_busy  in  1  core busy

Behaviour:
- Reset is synchronous and active-high. On `wb_rst_i`:
  - `wbs_ack_o`=0, `wbs_dat_o`=0.
  - `mem_csb`=4'hF, `mem_web`=1, `mem_addr`=0, `mem_wdata`=0.
  - `mode`=0, `debug`=0, `fsm_start`=0.
  - Done-sticky bit=0, lower-half hold register=0.
  - An in-flight transaction is dropped with no ack.
- Decode uses `adr[31:16]`:
  - 0x3000: registers at offset `adr[4:2]`: 0 MODE (rw bit0), 1 DEBUG (rw bit0), 2 DONE (ro sticky, write 1 clears), 3 FSM_START (wo, write bit0=1 pulses), 4 FSM_BUSY (ro).
  - 0x3001 query, 0x3002 leaf, 0x3003 best, 0x3004 node.
  - Word index = `adr[MEM_ADDR_W+1:2]`; half select = `adr[1]` (0 lower, 1 upper, ignored for node).
  - Memory address with `adr[15:MEM_ADDR_W+2]` nonzero is unmapped.
- State machine: IDLE, MEM_RD, RD_CAP, ACK. Transactions start only in IDLE when `cyc&stb`.
- Write, sampled in cycle N:
  - Cycle N+1: `ack`=1.
  - Lower-half write to query/leaf/best loads the hold register only. No SRAM access.
  - Upper-half write commits `{dat_i, hold}` in cycle N+1: one selected `csb` low, `web`=0.
  - Node write commits `{0, dat_i[21:0]}` directly.
- Read, sampled in cycle N:
  - Cycle N+1: `csb` low, `web`=1.
  - Cycle N+2: rdata captured, selecting the half by `adr[1]`. Node data is zero-extended.
  - Cycle N+3: `ack`=1, with `dat_o` valid.
  - `dat_o` holds until the next read ack.
  - Register reads ack at N+1, with zero-extended bit fields.
- Ack handshake:
  - `ack` is exactly one cycle wide.
  - The FSM returns to IDLE after ack. If `stb` is still high, a new transaction starts the cycle after ack.
  - `cyc` dropping mid-read aborts: no ack, `csb` returns high.
- While `fsm_busy`=1:
  - Memory writes are acked with no SRAM strobe.
  - Memory reads are acked at N+1 with `dat_o`=0.
  - Register access is unaffected.
- FSM_START write while busy is ignored.
- Done sticky:
  - Set by `fsm_done`.
  - Cleared by a DONE write with bit0=1, or by a start pulse.
  - Set wins over a simultaneous clear.
- Unmapped read returns 0 and unmapped write has no effect; both ack at N+1.

Optional Feature:
- WBS_ADDR_TRAP_EN defined:
  - Unmapped accesses set a sticky error bit readable at 0x3000_0014, cleared by a write of 1.
  - Unmapped reads return 32'hBADD_0ADD.
- Undefined: no error register (0x3000_0014 is unmapped), and unmapped reads return 0.

Test Plan:
- Write 0x3002_0020 = 32'h1234_5678, then 0x3002_0022 = 32'h0000_00AB:
  - No SRAM strobe on the first write.
  - Second write: `csb[1]`=0, `web`=0, `mem_addr`=8, `mem_wdata`=64'h0000_00AB_1234_5678, ack 1 cycle after `stb`.
- Read 0x3003_0010 with `best_rdata`=64'hCAFE_0001_0000_0155 → `csb[2]` low at N+1, ack at N+3, `dat_o`=32'h0000_0155. Repeat at 0x3003_0012 → 32'hCAFE_0001.
- Write node 0x3004_0004 = {10'b0, 11'd55, 11'd1} → `csb[3]`=0, `mem_addr`=1, `mem_wdata`=64'h0000_0000_0001_B801.
- Write FSM_START=1 → `fsm_start` high for exactly 1 cycle. Then:
  - Pulse `fsm_done`; read DONE → 1.
  - Write DONE=1; read DONE → 0.
  - With `fsm_busy`=1, write FSM_START → no pulse.
- Hold `stb` high through 3 back-to-back writes → 3 distinct one-cycle acks. Then assert `wb_rst_i` during MEM_RD → no ack, `csb`=4'hF, hold=0.
- Read 0x3005_0000:
  - Macro undefined: ack at N+1, `dat_o`=0.
  - Macro defined: `dat_o`=32'hBADD_0ADD, and 0x3000_0014 reads 1.

Source files
------------

// File: rtl/wbs_mem_responder.sv
// Wishbone slave for the ANN accelerator: CSRs plus query/leaf/best/node SRAM windows.
// Define WBS_ADDR_TRAP_EN to add a sticky unmapped-access error register at 0x3000_0014.
module wbs_mem_responder #(
    parameter int MEM_ADDR_W  = 12,
    parameter int MEM_DATA_W  = 64,
    parameter int NODE_DATA_W = 22
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_we_i,
    input  logic [3:0]            wbs_sel_i,
    input  logic [31:0]           wbs_adr_i,
    input  logic [31:0]           wbs_dat_i,
    output logic                  wbs_ack_o,
    output logic [31:0]           wbs_dat_o,
    output logic [3:0]            mem_csb,
    output logic                  mem_web,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [MEM_DATA_W-1:0] mem_wdata,
    input  logic [MEM_DATA_W-1:0] query_rdata,
    input  logic [MEM_DATA_W-1:0] leaf_rdata,
    input  logic [MEM_DATA_W-1:0] best_rdata,
    input  logic [NODE_DATA_W-1:0] node_rdata,
    output logic                  mode,
    output logic                  debug,
    output logic                  fsm_start,
    input  logic                  fsm_done,
    input  logic                  fsm_busy
);

`ifdef WBS_ADDR_TRAP_EN
    localparam bit          TRAP_EN        = 1'b1;
    localparam logic [31:0] UNMAPPED_RDATA = 32'hBADD_0ADD;
`else
    localparam bit          TRAP_EN        = 1'b0;
    localparam logic [31:0] UNMAPPED_RDATA = 32'h0000_0000;
`endif

    localparam logic [15:0] PG_REG  = 16'h3000;
    localparam logic [15:0] PG_QRY  = 16'h3001;
    localparam logic [15:0] PG_LEAF = 16'h3002;
    localparam logic [15:0] PG_BEST = 16'h3003;
    localparam logic [15:0] PG_NODE = 16'h3004;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEM_RD,
        S_RD_CAP,
        S_ACK
    } state_t;

    state_t state_q, state_d;

    logic                  ack_d, start_d;
    logic [31:0]           dat_d;
    logic [3:0]            csb_d;
    logic                  web_d;
    logic [MEM_ADDR_W-1:0] addr_d;
    logic [MEM_DATA_W-1:0] wdata_d;
    logic                  mode_d, debug_d;
    logic                  done_q, done_clr;
    logic                  err_q, err_set, err_clr;
    logic [31:0]           hold_q, hold_d;
    logic [3:0]            rd_sel_q, rd_sel_d;
    logic                  rd_hi_q, rd_hi_d;

    logic                  req;
    logic [15:0]           page;
    logic [2:0]            reg_off;
    logic [MEM_ADDR_W-1:0] word;
    logic                  half_hi;
    logic                  out_of_range;
    logic [3:0]            region;
    logic                  is_mem, is_reg, unmapped;
    logic [31:0]           reg_rdata;
    logic [31:0]           cap_data;
    logic [MEM_DATA_W-1:0] cap_src;
    logic                  unused_ok;

    assign req          = wbs_cyc_i & wbs_stb_i;
    assign page         = wbs_adr_i[31:16];
    assign reg_off      = wbs_adr_i[4:2];
    assign word         = wbs_adr_i[MEM_ADDR_W+1:2];
    assign half_hi      = wbs_adr_i[1];
    assign out_of_range = |wbs_adr_i[15:MEM_ADDR_W+2];
    assign unused_ok    = ^{wbs_sel_i, wbs_adr_i[0]};

    assign region = {page == PG_NODE, page == PG_BEST,
                     page == PG_LEAF, page == PG_QRY};
    assign is_mem = (|region) & ~out_of_range;
    assign is_reg = (page == PG_REG) &
                    ((reg_off <= 3'd4) || (TRAP_EN && reg_off == 3'd5));
    assign unmapped = ~is_mem & ~is_reg;

    always_comb begin
        reg_rdata = '0;
        case (reg_off)
            3'd0:    reg_rdata[0] = mode;
            3'd1:    reg_rdata[0] = debug;
            3'd2:    reg_rdata[0] = done_q;
            3'd4:    reg_rdata[0] = fsm_busy;
            3'd5:    reg_rdata[0] = err_q;
            default: reg_rdata    = '0;
        endcase
    end

    // Node words are narrow and have no halves; other regions pick a 32-bit half.
    always_comb begin
        cap_src  = best_rdata;
        cap_data = '0;
        if (rd_sel_q[0]) begin
            cap_src = query_rdata;
        end else if (rd_sel_q[1]) begin
            cap_src = leaf_rdata;
        end
        if (rd_sel_q[3]) begin
            cap_data = {{(32-NODE_DATA_W){1'b0}}, node_rdata};
        end else if (rd_hi_q) begin
            cap_data = cap_src[32 +: 32];
        end else begin
            cap_data = cap_src[0 +: 32];
        end
    end

    always_comb begin
        state_d  = state_q;
        ack_d    = 1'b0;
        dat_d    = wbs_dat_o;
        csb_d    = 4'hF;
        web_d    = 1'b1;
        addr_d   = mem_addr;
        wdata_d  = mem_wdata;
        mode_d   = mode;
        debug_d  = debug;
        start_d  = 1'b0;
        done_clr = 1'b0;
        err_set  = 1'b0;
        err_clr  = 1'b0;
        hold_d   = hold_q;
        rd_sel_d = rd_sel_q;
        rd_hi_d  = rd_hi_q;

        case (state_q)
            S_IDLE: begin
                if (req && wbs_we_i) begin
                    ack_d   = 1'b1;
                    state_d = S_ACK;
                    if (is_mem) begin
                        // The core owns the SRAMs while busy.
                        if (!fsm_busy) begin
                            if (region[3]) begin
                                csb_d   = ~region;
                                web_d   = 1'b0;
                                addr_d  = word;
                                wdata_d = {{(MEM_DATA_W-NODE_DATA_W){1'b0}},
                                           wbs_dat_i[NODE_DATA_W-1:0]};
                            end else if (!half_hi) begin
                                hold_d = wbs_dat_i;
                            end else begin
                                csb_d   = ~region;
                                web_d   = 1'b0;
                                addr_d  = word;
                                wdata_d = {wbs_dat_i, hold_q};
                            end
                        end
                    end else if (is_reg) begin
                        case (reg_off)
                            3'd0:    mode_d   = wbs_dat_i[0];
                            3'd1:    debug_d  = wbs_dat_i[0];
                            3'd2:    done_clr = wbs_dat_i[0];
                            3'd3:    start_d  = wbs_dat_i[0] & ~fsm_busy;
                            3'd5:    err_clr  = wbs_dat_i[0];
                            default: ;
                        endcase
                    end else begin
                        err_set = TRAP_EN;
                    end
                end else if (req) begin
                    if (is_mem && !fsm_busy) begin
                        csb_d    = ~region;
                        addr_d   = word;
                        rd_sel_d = region;
                        rd_hi_d  = half_hi;
                        state_d  = S_MEM_RD;
                    end else begin
                        ack_d   = 1'b1;
                        state_d = S_ACK;
                        err_set = TRAP_EN & unmapped;
                        if (is_mem) begin
                            dat_d = '0;
                        end else if (is_reg) begin
                            dat_d = reg_rdata;
                        end else begin
                            dat_d = UNMAPPED_RDATA;
                        end
                    end
                end
            end
            S_MEM_RD: begin
                state_d = wbs_cyc_i ? S_RD_CAP : S_IDLE;
            end
            S_RD_CAP: begin
                if (wbs_cyc_i) begin
                    ack_d   = 1'b1;
                    dat_d   = cap_data;
                    state_d = S_ACK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            mem_csb   <= 4'hF;
            mem_web   <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mode      <= 1'b0;
            debug     <= 1'b0;
            fsm_start <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            hold_q    <= '0;
            rd_sel_q  <= '0;
            rd_hi_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wbs_ack_o <= ack_d;
            wbs_dat_o <= dat_d;
            mem_csb   <= csb_d;
            mem_web   <= web_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            mode      <= mode_d;
            debug     <= debug_d;
            fsm_start <= start_d;
            // A done pulse beats a same-cycle clear.
            done_q    <= fsm_done | (done_q & ~(done_clr | start_d));
            err_q     <= TRAP_EN & (err_set | (err_q & ~err_clr));
            hold_q    <= hold_d;
            rd_sel_q  <= rd_sel_d;
            rd_hi_q   <= rd_hi_d;
        end
    end

endmodule

// File: tb/tb_wbs_mem_responder.sv
// Directed bench for wbs_mem_responder: decode, SRAM strobes, CSRs, handshake, reset.
module tb_wbs_mem_responder;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_cyc_i = 1'b0;
    logic        wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'hF;
    logic [31:0] wbs_adr_i = '0;
    logic [31:0] wbs_dat_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [3:0]  mem_csb;
    logic        mem_web;
    logic [11:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] query_rdata = 64'h1111_2222_3333_4444;
    logic [63:0] leaf_rdata  = 64'h5555_6666_7777_8888;
    logic [63:0] best_rdata  = 64'hCAFE_0001_0000_0155;
    logic [21:0] node_rdata  = 22'h1B801;
    logic        mode, debug, fsm_start;
    logic        fsm_done = 1'b0;
    logic        fsm_busy = 1'b0;

    wbs_mem_responder dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .wbs_stb_i   (wbs_stb_i),
        .wbs_cyc_i   (wbs_cyc_i),
        .wbs_we_i    (wbs_we_i),
        .wbs_sel_i   (wbs_sel_i),
        .wbs_adr_i   (wbs_adr_i),
        .wbs_dat_i   (wbs_dat_i),
        .wbs_ack_o   (wbs_ack_o),
        .wbs_dat_o   (wbs_dat_o),
        .mem_csb     (mem_csb),
        .mem_web     (mem_web),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .query_rdata (query_rdata),
        .leaf_rdata  (leaf_rdata),
        .best_rdata  (best_rdata),
        .node_rdata  (node_rdata),
        .mode        (mode),
        .debug       (debug),
        .fsm_start   (fsm_start),
        .fsm_done    (fsm_done),
        .fsm_busy    (fsm_busy)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_checks = 0;
    int n_errors = 0;

    int ack_cnt = 0, ack_run = 0, ack_max = 0;
    int start_cnt = 0, start_run = 0, start_max = 0;

    always @(negedge wb_clk_i) begin
        if (wbs_ack_o) begin
            ack_cnt <= ack_cnt + 1;
            ack_run <= ack_run + 1;
            if (ack_run + 1 > ack_max) ack_max <= ack_run + 1;
        end else begin
            ack_run <= 0;
        end
        if (fsm_start) begin
            start_cnt <= start_cnt + 1;
            start_run <= start_run + 1;
            if (start_run + 1 > start_max) start_max <= start_run + 1;
        end else begin
            start_run <= 0;
        end
    end

    logic        stb_seen;
    int          stb_at;
    logic [3:0]  s_csb;
    logic        s_web;
    logic [11:0] s_addr;
    logic [63:0] s_wdata;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at posedge+1 with the FSM idle; returns after one idle cycle.
    task automatic wb_xfer(input logic we, input logic [31:0] adr,
                           input logic [31:0] dat,
                           output logic [31:0] rdat, output int lat);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        stb_seen  = 1'b0;
        stb_at    = 0;
        lat       = 0;
        rdat      = '0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge wb_clk_i);
            #1;
            if (mem_csb != 4'hF && !stb_seen) begin
                stb_seen = 1'b1;
                stb_at   = n;
                s_csb    = mem_csb;
                s_web    = mem_web;
                s_addr   = mem_addr;
                s_wdata  = mem_wdata;
            end
            if (wbs_ack_o) begin
                lat  = n;
                rdat = wbs_dat_o;
                break;
            end
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic pulse_done();
        fsm_done = 1'b1;
        @(posedge wb_clk_i);
        #1;
        fsm_done = 1'b0;
    endtask

    logic [31:0] rd;
    int          lat, a0, s0;

    initial begin
        repeat (3) @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b0;

        check("rst_ack", wbs_ack_o, 0);
        check("rst_dat", wbs_dat_o, 0);
        check("rst_csb", mem_csb, 4'hF);
        check("rst_web", mem_web, 1);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_mode", mode, 0);
        check("rst_debug", debug, 0);
        check("rst_start", fsm_start, 0);

        // Split 64-bit leaf write
        wb_xfer(1, 32'h3002_0020, 32'h1234_5678, rd, lat);
        check("lo_lat", lat, 1);
        check("lo_nostb", stb_seen, 0);
        wb_xfer(1, 32'h3002_0022, 32'h0000_00AB, rd, lat);
        check("hi_lat", lat, 1);
        check("hi_stb_at", stb_at, 1);
        check("hi_csb", s_csb, 4'b1101);
        check("hi_web", s_web, 0);
        check("hi_addr", s_addr, 8);
        check("hi_wdata", s_wdata, 64'h0000_00AB_1234_5678);

        // Best reads, both halves
        wb_xfer(0, 32'h3003_0010, 0, rd, lat);
        check("rdlo_stb_at", stb_at, 1);
        check("rdlo_csb", s_csb, 4'b1011);
        check("rdlo_web", s_web, 1);
        check("rdlo_addr", s_addr, 4);
        check("rdlo_lat", lat, 3);
        check("rdlo_dat", rd, 32'h0000_0155);
        wb_xfer(0, 32'h3003_0012, 0, rd, lat);
        check("rdhi_lat", lat, 3);
        check("rdhi_dat", rd, 32'hCAFE_0001);

        // Node write; dat_o must keep the last read value
        wb_xfer(1, 32'h3004_0004, {10'b0, 11'd55, 11'd1}, rd, lat);
        check("node_csb", s_csb, 4'b0111);
        check("node_web", s_web, 0);
        check("node_addr", s_addr, 1);
        check("node_wdata", s_wdata, 64'h0000_0000_0001_B801);
        check("dat_hold", wbs_dat_o, 32'hCAFE_0001);
        wb_xfer(0, 32'h3004_0004, 0, rd, lat);
        check("node_rd_lat", lat, 3);
        check("node_rd_dat", rd, 32'h0001_B801);

        // Mode register
        wb_xfer(1, 32'h3000_0000, 1, rd, lat);
        check("mode_out", mode, 1);
        wb_xfer(0, 32'h3000_0000, 0, rd, lat);
        check("mode_rd_lat", lat, 1);
        check("mode_rd", rd, 1);

        // Start pulse and done sticky
        s0 = start_cnt;
        wb_xfer(1, 32'h3000_000C, 1, rd, lat);
        check("start_cnt", start_cnt - s0, 1);
        check("start_width", start_max, 1);
        pulse_done();
        wb_xfer(0, 32'h3000_0008, 0, rd, lat);
        check("done_set", rd, 1);
        wb_xfer(1, 32'h3000_0008, 1, rd, lat);
        wb_xfer(0, 32'h3000_0008, 0, rd, lat);
        check("done_clr", rd, 0);
        pulse_done();
        wb_xfer(1, 32'h3000_000C, 1, rd, lat);
        wb_xfer(0, 32'h3000_0008, 0, rd, lat);
        check("done_start_clr", rd, 0);

        // Busy behaviour
        fsm_busy = 1'b1;
        s0 = start_cnt;
        wb_xfer(1, 32'h3000_000C, 1, rd, lat);
        check("busy_start", start_cnt - s0, 0);
        wb_xfer(1, 32'h3001_0002, 32'hDEAD_BEEF, rd, lat);
        check("busy_wr_lat", lat, 1);
        check("busy_wr_nostb", stb_seen, 0);
        wb_xfer(0, 32'h3003_0010, 0, rd, lat);
        check("busy_rd_lat", lat, 1);
        check("busy_rd_dat", rd, 0);
        check("busy_rd_nostb", stb_seen, 0);
        wb_xfer(0, 32'h3000_0010, 0, rd, lat);
        check("busy_reg", rd, 1);
        fsm_busy = 1'b0;

        // Unmapped accesses
        wb_xfer(1, 32'h3001_C002, 32'h1, rd, lat);
        check("oor_wr_lat", lat, 1);
        check("oor_wr_nostb", stb_seen, 0);
        wb_xfer(0, 32'h3005_0000, 0, rd, lat);
        check("unm_lat", lat, 1);
`ifdef WBS_ADDR_TRAP_EN
        check("unm_dat", rd, 32'hBADD_0ADD);
        wb_xfer(0, 32'h3000_0014, 0, rd, lat);
        check("err_set", rd, 1);
        wb_xfer(1, 32'h3000_0014, 1, rd, lat);
        wb_xfer(0, 32'h3000_0014, 0, rd, lat);
        check("err_clr", rd, 0);
`else
        check("unm_dat", rd, 0);
        wb_xfer(0, 32'h3000_0014, 0, rd, lat);
        check("err_unm_lat", lat, 1);
        check("err_unm_dat", rd, 0);
`endif

        // cyc dropped mid-read
        a0 = ack_cnt;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b0;
        wbs_adr_i = 32'h3002_0000;
        @(posedge wb_clk_i);
        #1;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        repeat (4) @(posedge wb_clk_i);
        #1;
        check("abort_noack", ack_cnt - a0, 0);
        check("abort_csb", mem_csb, 4'hF);
        wb_xfer(0, 32'h3000_0000, 0, rd, lat);
        check("abort_idle", lat, 1);

        // stb held across three writes
        a0 = ack_cnt;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b1;
        wbs_adr_i = 32'h3000_0004;
        wbs_dat_i = 32'h1;
        repeat (5) @(posedge wb_clk_i);
        #1;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        repeat (2) @(posedge wb_clk_i);
        #1;
        check("b2b_acks", ack_cnt - a0, 3);
        check("ack_width", ack_max, 1);
        check("b2b_debug", debug, 1);

        // Reset during MEM_RD
        wb_xfer(1, 32'h3001_0000, 32'h5555_5555, rd, lat);
        a0 = ack_cnt;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b0;
        wbs_adr_i = 32'h3001_0000;
        @(posedge wb_clk_i);
        #1;
        check("mrd_csb", mem_csb, 4'b1110);
        wb_rst_i  = 1'b1;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        @(posedge wb_clk_i);
        #1;
        check("rst_mrd_csb", mem_csb, 4'hF);
        check("rst_mrd_ack", wbs_ack_o, 0);
        repeat (3) @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b0;
        check("rst_mrd_noack", ack_cnt - a0, 0);
        check("rst_mrd_debug", debug, 0);
        wb_xfer(1, 32'h3001_0002, 32'hAAAA_AAAA, rd, lat);
        check("rst_hold_csb", s_csb, 4'b1110);
        check("rst_hold", s_wdata, 64'hAAAA_AAAA_0000_0000);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
